// File: rtl/sobel_stream_unit.sv
// rtl/sobel_stream_unit.sv - streaming 3x3 Sobel engine with line buffers and valid/ready handshakes
module sobel_stream_unit #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inicia,
  input  logic [1:0]       modo,
  input  logic [PIX_W-1:0] limiar,
  input  logic [PIX_W-1:0] in_dados,
  input  logic             in_valido,
  output logic             in_pronto,
  output logic [PIX_W-1:0] out_dados,
  output logic             out_valido,
  input  logic             out_pronto,
  output logic             ocupado,
  output logic             fim_imagem
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = PIX_W + 4;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [1:0]       modo_r;
  logic [PIX_W-1:0] limiar_r;
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb2 [IMG_W];
  logic [PIX_W-1:0] win_a [3];
  logic [PIX_W-1:0] win_b [3];
  logic [PIX_W-1:0] col_new [3];
  logic             accept, take, last_pix, load;
  logic [AW-1:0]    gx_pos, gx_neg, gy_pos, gy_neg, abs_gx, abs_gy, mag;
  logic signed [AW-1:0] gx, gy;
  logic [PIX_W-1:0] result;

  function automatic logic [AW-1:0] ext(input logic [PIX_W-1:0] p);
    return {4'b0000, p};
  endfunction

  function automatic logic [PIX_W-1:0] sat(input logic [AW-1:0] v);
    return (|v[AW-1:PIX_W]) ? {PIX_W{1'b1}} : v[PIX_W-1:0];
  endfunction

  assign accept   = in_valido && in_pronto;
  assign take     = out_valido && out_pronto;
  assign last_pix = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
  assign load     = accept && (row >= RW'(2)) && (col >= CW'(2));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (inicia) state_nx = RUN;
      RUN:   if (accept && last_pix) state_nx = FLUSH;
      FLUSH: if (!out_valido || out_pronto) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // in_pronto looks through to out_pronto so a taken result frees the slot in the same cycle
  always_comb begin
    in_pronto  = (state == RUN) && !(out_valido && !out_pronto);
    ocupado    = (state == RUN) || (state == FLUSH);
    fim_imagem = (state == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      modo_r     <= '0;
      limiar_r   <= '0;
      out_dados  <= '0;
      out_valido <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        win_a[i] <= '0;
        win_b[i] <= '0;
      end
    end else begin
      if (state == IDLE && inicia) begin
        col      <= '0;
        row      <= '0;
        modo_r   <= modo;
        limiar_r <= limiar;
      end else if (accept) begin
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          win_a[i] <= win_b[i];
          win_b[i] <= col_new[i];
        end
      end
      if (load) begin
        out_dados  <= result;
        out_valido <= 1'b1;
      end else if (take) begin
        out_valido <= 1'b0;
      end
    end
  end

  // line buffers are always written before being read within a frame, so no reset
  always_ff @(posedge clock) begin
    if (accept) begin
      lb2[col] <= lb1[col];
      lb1[col] <= in_dados;
    end
  end

  // window p[r][c]: c=0 win_a, c=1 win_b, c=2 the column entering this cycle
  always_comb begin
    col_new[0] = lb2[col];
    col_new[1] = lb1[col];
    col_new[2] = in_dados;
    gx_pos = ext(col_new[0]) + (ext(col_new[1]) << 1) + ext(col_new[2]);
    gx_neg = ext(win_a[0]) + (ext(win_a[1]) << 1) + ext(win_a[2]);
    gy_pos = ext(win_a[2]) + (ext(win_b[2]) << 1) + ext(col_new[2]);
    gy_neg = ext(win_a[0]) + (ext(win_b[0]) << 1) + ext(col_new[0]);
    gx     = signed'(gx_pos - gx_neg);
    gy     = signed'(gy_pos - gy_neg);
    abs_gx = gx[AW-1] ? AW'(-gx) : AW'(gx);
    abs_gy = gy[AW-1] ? AW'(-gy) : AW'(gy);
    mag    = abs_gx + abs_gy;
    case (modo_r)
      2'b00:   result = sat(mag);
      2'b01:   result = (mag > ext(limiar_r)) ? {PIX_W{1'b1}} : '0;
      2'b10:   result = sat(abs_gx);
      default: result = sat(abs_gy);
    endcase
  end

endmodule

// File: tb/tb_sobel_stream_unit.sv
// tb/tb_sobel_stream_unit.sv - self-checking bench for sobel_stream_unit on 4x4 frames
module tb_sobel_stream_unit;
  localparam int W = 4;
  localparam int H = 4;
  localparam int NPIX = W * H;
  localparam int NRES = (W - 2) * (H - 2);

  logic       clock = 0;
  logic       reset = 1;
  logic       inicia = 0;
  logic [1:0] modo = 0;
  logic [7:0] limiar = 0;
  logic [7:0] in_dados = 0;
  logic       in_valido = 0;
  logic       in_pronto;
  logic [7:0] out_dados;
  logic       out_valido;
  logic       out_pronto = 0;
  logic       ocupado;
  logic       fim_imagem;

  sobel_stream_unit #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clock(clock), .reset(reset), .inicia(inicia), .modo(modo), .limiar(limiar),
    .in_dados(in_dados), .in_valido(in_valido), .in_pronto(in_pronto),
    .out_dados(out_dados), .out_valido(out_valido), .out_pronto(out_pronto),
    .ocupado(ocupado), .fim_imagem(fim_imagem)
  );

  always #5 clock = ~clock;

  typedef struct {
    int pat;
    int md;
    int lim;
    int bp;
    int exp;
  } vec_t;

  vec_t tbl [8];
  int   frame [NPIX];
  int   got [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic fill_pattern(input int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0:       frame[r*W + c] = 77;
          1:       frame[r*W + c] = (c >= 2) ? 10 : 0;
          default: frame[r*W + c] = (c >= 2) ? 255 : 0;
        endcase
  endtask

  function automatic int px(int r, int c);
    return frame[r*W + c];
  endfunction

  // reference: Sobel of the 3x3 neighbourhood centred at (r,c) straight from the frame array
  function automatic int model(int r, int c, int md, int lim);
    int gx, gy, ax, ay, mag, v;
    gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
    gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    mag = ax + ay;
    case (md)
      0:       v = mag;
      1:       v = (mag > lim) ? 255 : 0;
      2:       v = ax;
      default: v = ay;
    endcase
    return (v > 255) ? 255 : v;
  endfunction

  task automatic run_frame(input int md, input int lim, input int bp, input bit rnd, input int abort_after);
    int idx = 0, hold = 0, cyc = 0, fims = 0, post = 0;
    bit fim_early = 0, bp_bad = 0, done = 0;
    got.delete();
    @(negedge clock);
    inicia = 1;
    modo = 2'(md);
    limiar = 8'(lim);
    @(posedge clock);
    while (!done && cyc < 2000) begin
      @(negedge clock);
      inicia = 0;
      modo = 2'($urandom);
      limiar = 8'($urandom);
      if (bp > 0) begin
        if (out_valido && hold < bp) begin
          out_pronto = 0;
          hold++;
        end else out_pronto = 1;
      end else out_pronto = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valido = (idx < NPIX) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_dados = (idx < NPIX) ? 8'(frame[idx]) : 8'($urandom);
      #1;
      if (out_valido && !out_pronto && in_pronto) bp_bad = 1;
      if (fim_imagem) begin
        fims++;
        if (got.size() != NRES) fim_early = 1;
      end
      if (out_valido && out_pronto) begin
        got.push_back(int'(out_dados));
        hold = 0;
      end
      if (in_valido && in_pronto) idx++;
      if (abort_after >= 0 && idx >= abort_after) done = 1;
      if (fims > 0) post++;
      if (post > 3) done = 1;
      cyc++;
    end
    chk("frame_finished_in_budget", int'(done), 1);
    chk("in_pronto_low_while_held", int'(bp_bad), 0);
    if (abort_after < 0) begin
      chk("fim_imagem_pulses", fims, 1);
      chk("fim_before_last_taken", int'(fim_early), 0);
      chk("result_count", got.size(), NRES);
      chk("ocupado_after_frame", int'(ocupado), 0);
    end
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 40};
    tbl[2] = '{1, 3, 0, 0, 0};
    tbl[3] = '{1, 2, 0, 0, 40};
    tbl[4] = '{2, 0, 0, 0, 255};
    tbl[5] = '{1, 1, 39, 0, 255};
    tbl[6] = '{1, 1, 40, 0, 0};
    tbl[7] = '{1, 0, 0, 5, 40};

    repeat (3) @(posedge clock);
    #1;
    chk("reset_in_pronto", int'(in_pronto), 0);
    chk("reset_out_valido", int'(out_valido), 0);
    chk("reset_out_dados", int'(out_dados), 0);
    chk("reset_ocupado", int'(ocupado), 0);
    chk("reset_fim_imagem", int'(fim_imagem), 0);
    @(negedge clock);
    reset = 0;

    for (int v = 0; v < 8; v++) begin
      fill_pattern(tbl[v].pat);
      run_frame(tbl[v].md, tbl[v].lim, tbl[v].bp, 1'b0, -1);
      for (int k = 0; k < got.size() && k < NRES; k++)
        chk($sformatf("table_vec%0d_res%0d", v, k), got[k], tbl[v].exp);
    end

    for (int f = 0; f < 6; f++) begin
      int md, lim;
      for (int i = 0; i < NPIX; i++) frame[i] = (f == 5) ? ($urandom_range(0, 1) * 255) : $urandom_range(0, 255);
      md = $urandom_range(0, 3);
      lim = $urandom_range(0, 255);
      run_frame(md, lim, 0, 1'b1, -1);
      for (int k = 0; k < got.size() && k < NRES; k++)
        chk($sformatf("random_f%0d_res%0d", f, k), got[k], model(1 + k / (W - 2), 1 + k % (W - 2), md, lim));
    end

    fill_pattern(0);
    run_frame(0, 0, 0, 1'b0, 10);
    @(negedge clock);
    in_valido = 0;
    reset = 1;
    #1;
    chk("midreset_in_pronto", int'(in_pronto), 0);
    chk("midreset_out_valido", int'(out_valido), 0);
    chk("midreset_out_dados", int'(out_dados), 0);
    chk("midreset_ocupado", int'(ocupado), 0);
    chk("midreset_fim_imagem", int'(fim_imagem), 0);
    @(negedge clock);
    reset = 0;
    run_frame(0, 0, 0, 1'b0, -1);
    for (int k = 0; k < got.size() && k < NRES; k++)
      chk($sformatf("after_reset_res%0d", k), got[k], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sobel_stream_unit.md
Name: sobel_stream_unit

Overview:
- Parametrised streaming Sobel engine. It replaces the fixed-size processing unit that sits between the UART receiver and transmitter in the Sobel datapath.
- Accepts one raster-order frame of IMG_W x IMG_H pixels and keeps two line buffers plus a 3x3 window.
- Emits the (IMG_W-2)*(IMG_H-2) interior results in raster order.
- Uses valid/ready handshakes on both sides, selectable output mode and threshold, and signals end of frame.

Parameters:
- IMG_W, 64, pixels per line; must be >=3.
- IMG_H, 64, lines per frame; must be >=3.
- PIX_W, 8, bits per input and output pixel.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- inicia  in  1  single-cycle start pulse; samples modo and limiar
- modo  in  2  00 |gx|+|gy|, 01 threshold, 10 |gx|, 11 |gy|
- limiar  in  PIX_W  threshold for modo 01
- in_dados  in  PIX_W  input pixel
- in_valido  in  1  in_dados valid
- in_pronto  out  1  engine accepts a pixel this cycle
- out_dados  out  PIX_W  result pixel
- out_valido  out  1  out_dados valid, held until taken
- out_pronto  in  1  downstream accepts a result
- ocupado  out  1  high in RUN and FLUSH
- fim_imagem  out  1  one-cycle pulse once the last result has been taken

Behaviour:
- Reset values: in_pronto=0, out_valido=0, out_dados=0, ocupado=0, fim_imagem=0; counters 0; state IDLE. Line-buffer RAM is not reset, because its contents are never used before being written in the current frame.
- Input acceptance: a pixel is accepted when in_valido && in_pronto. in_pronto = (state==RUN) && !(out_valido && !out_pronto). This is combinational from out_pronto.
- Counters: col counts 0..IMG_W-1; on wrap it returns to 0 and row increments, row counting 0..IMG_H-1.
- Window per accepted pixel:
  - the column shift register shifts in {linebuf2[col], linebuf1[col], in_dados};
  - then linebuf2[col] <= linebuf1[col] and linebuf1[col] <= in_dados.
- Output generation: when the accepted pixel has row>=2 and col>=2, the result for centre (row-1, col-1) is registered. out_valido rises the next cycle (latency 1).
- Output handshake: out_valido clears on out_valido && out_pronto unless a new result is loaded in the same cycle. A new result is loaded in the same cycle it is taken, giving back-to-back throughput of 1 pixel/cycle. No result is ever dropped or duplicated.
- Arithmetic, with window p[r][c], r=0 oldest line, c=0 oldest column:
  - gx = (p02+2p12+p22)-(p00+2p10+p20);
  - gy = (p20+2p21+p22)-(p00+2p01+p02);
  - both signed, PIX_W+4 bits;
  - mag = |gx|+|gy|, saturated to 2^PIX_W-1;
  - modes 10/11 use |gx| or |gy|, also saturated;
  - mode 01 outputs all-ones if mag > limiar (strict), else 0.
- State IDLE:
  - inicia -> RUN; latches modo and limiar and clears col/row;
  - inicia with IMG_W/IMG_H violated is not supported.
- State RUN:
  - accepts pixels;
  - after accepting pixel (IMG_H-1, IMG_W-1) -> FLUSH.
- State FLUSH:
  - in_pronto=0;
  - when no unreturned result remains (out_valido=0, or it is taken this cycle) -> DONE.
- State DONE: fim_imagem=1 for exactly one cycle -> IDLE.
- inicia outside IDLE is ignored. modo and limiar changes during a frame have no effect.
- Reset mid-frame: asynchronous return to IDLE; any pending out_valido is dropped; no fim_imagem.
- Result count per frame is exactly (IMG_W-2)*(IMG_H-2), checked by the bench.

Test Plan (all with IMG_W=4, IMG_H=4, PIX_W=8):
- Constant frame: all 16 pixels = 77, modo 00, out_pronto=1 -> 4 results of 0, then one fim_imagem pulse, ocupado falls.
- Vertical edge: each row is 0,0,10,10, modo 00 -> four results of 40; modo 11 -> four results of 0; modo 10 -> four results of 40.
- Saturation: each row is 0,0,255,255, modo 00 -> four results of 255 (raw 1020 clipped).
- Threshold: edge frame 0,0,10,10 with modo 01 -> limiar 39 gives four results of 255; limiar 40 gives four results of 0.
- Backpressure: edge frame fed with in_valido constantly 1 and out_pronto low for 5 cycles at each result -> in_pronto=0 while a result is held; exactly 4 results of 40 in order; fim_imagem only after the 4th is taken.
- Reset mid-frame: assert reset after 10 accepted pixels -> outputs return to reset values immediately. A fresh inicia plus a full constant frame then yields exactly 4 zeros and one fim_imagem.
